// File: rtl/arbitro_jogadas.sv
// -----------------------------------------------------------------------------
// arbitro_jogadas
// Move arbiter between the two player keypads and the game control unit.
// Tracks whose turn it is, accepts presses only from the current player's
// 9-key pad, validates each press against the target board occupancy map and
// emits a one-cycle move pulse with the encoded cell index. A per-turn timer
// forces an automatic move (lowest free cell) when it expires.
//
// Ports
//   clock            system clock, rising edge
//   reset            asynchronous, active-low
//   habilita         control unit is waiting for a move
//   troca_jogador    one-cycle pulse, toggles the current player
//   zera_vez         forces the current player to 0 (wins over troca_jogador)
//   botoes_j1/_j2    player keypads, bit i = cell i
//   ocupadas         target board occupancy, bit i = cell i taken
//   tem_jogada       one-cycle pulse, valid move on posicao
//   posicao          cell index 0..8, held until the next move
//   jogador          current player (0 = j1, 1 = j2)
//   jogada_invalida  one-cycle pulse, press rejected
//   timeout          one-cycle pulse, turn timer expired
//   db_estado        debug state code
// -----------------------------------------------------------------------------
module arbitro_jogadas #(
    parameter int TIMEOUT = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic       troca_jogador,
    input  logic       zera_vez,
    input  logic [8:0] botoes_j1,
    input  logic [8:0] botoes_j2,
    input  logic [8:0] ocupadas,
    output logic       tem_jogada,
    output logic [3:0] posicao,
    output logic       jogador,
    output logic       jogada_invalida,
    output logic       timeout,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        LIBERA  = 3'd1,
        ESPERA  = 3'd2,
        VALIDA  = 3'd3,
        ACEITA  = 3'd4,
        REJEITA = 3'd5,
        TEMPO   = 3'd6
    } estado_t;

    localparam logic [15:0] LIMITE = 16'(TIMEOUT - 1);

    estado_t     estado_q, estado_d;
    logic [15:0] timer_q, timer_d;
    logic [8:0]  tecla_q, tecla_d;
    logic [3:0]  posicao_q, posicao_d;
    logic        jogador_q, jogador_d;

    logic [8:0]  ativo;
    logic        expirado;
    logic        tecla_um_hot;
    logic        tabuleiro_cheio;
    logic [3:0]  idx_tecla;
    logic [3:0]  idx_livre;

    assign ativo           = jogador_q ? botoes_j2 : botoes_j1;
    // ">=" rather than "==": VALIDA/REJEITA keep counting without checking, so
    // the timer may step past the limit there; this still ends the turn.
    assign expirado        = (timer_q >= LIMITE);
    assign tecla_um_hot    = (tecla_q != 9'd0) && ((tecla_q & (tecla_q - 9'd1)) == 9'd0);
    assign tabuleiro_cheio = (ocupadas == 9'h1FF);

    // Index of the captured key; only meaningful when tecla_q is one-hot.
    always_comb begin
        idx_tecla = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (tecla_q[i]) begin
                idx_tecla = 4'(i);
            end
        end
    end

    // Lowest free cell: scan downwards so the last hit is the lowest index.
    always_comb begin
        idx_livre = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (!ocupadas[i]) begin
                idx_livre = 4'(i);
            end
        end
    end

    // Turn register: zera_vez wins over troca_jogador, evaluated in every state.
    always_comb begin
        jogador_d = jogador_q;
        if (zera_vez) begin
            jogador_d = 1'b0;
        end else if (troca_jogador) begin
            jogador_d = ~jogador_q;
        end
    end

    // Next-state logic
    always_comb begin
        estado_d  = estado_q;
        tecla_d   = tecla_q;
        posicao_d = posicao_q;
        case (estado_q)
            OCIOSO: begin
                if (habilita) begin
                    estado_d = LIBERA;
                end
            end
            LIBERA: begin
                if (!habilita) begin
                    estado_d = OCIOSO;
                end else if (expirado) begin
                    estado_d = TEMPO;
                end else if (ativo == 9'd0) begin
                    estado_d = ESPERA;
                end
            end
            ESPERA: begin
                if (!habilita) begin
                    estado_d = OCIOSO;
                end else if (expirado) begin
                    estado_d = TEMPO;
                end else if (ativo != 9'd0) begin
                    tecla_d  = ativo;
                    estado_d = VALIDA;
                end
            end
            VALIDA: begin
                if (tecla_um_hot && ((tecla_q & ocupadas) == 9'd0)) begin
                    posicao_d = idx_tecla;
                    estado_d  = ACEITA;
                end else begin
                    estado_d = REJEITA;
                end
            end
            ACEITA:  estado_d = LIBERA;
            REJEITA: estado_d = LIBERA;
            TEMPO:   estado_d = LIBERA;
            default: estado_d = OCIOSO;
        endcase

        // The automatic move is loaded on the way into TEMPO so that posicao
        // is already valid while tem_jogada is high in TEMPO.
        if ((estado_d == TEMPO) && !tabuleiro_cheio) begin
            posicao_d = idx_livre;
        end
    end

    // Turn timer: rejections keep counting so a player cannot stall the turn.
    always_comb begin
        timer_d = timer_q;
        case (estado_q)
            LIBERA, ESPERA, VALIDA, REJEITA: begin
                if (timer_q != 16'hFFFF) begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: timer_d = 16'd0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= OCIOSO;
            timer_q   <= 16'd0;
            tecla_q   <= 9'd0;
            posicao_q <= 4'd0;
            jogador_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            timer_q   <= timer_d;
            tecla_q   <= tecla_d;
            posicao_q <= posicao_d;
            jogador_q <= jogador_d;
        end
    end

    // Moore outputs
    assign tem_jogada      = (estado_q == ACEITA) || ((estado_q == TEMPO) && !tabuleiro_cheio);
    assign jogada_invalida = (estado_q == REJEITA);
    assign timeout         = (estado_q == TEMPO);
    assign db_estado       = estado_q;
    assign posicao         = posicao_q;
    assign jogador         = jogador_q;

endmodule
